spi_tx_scheduler: RTL and testbench

//   Upstream feeder for the SPI master top level. Buffers bytes from a valid/ready producer in a FIFO.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync_fifo.sv | 51 +++++
 rtl/spi_tx_scheduler.sv | 100 ++++++++++
 tb/tb_spi_tx_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transmit path.
package spi_pkg;
  localparam int SPI_DATA_LENGTH = 8;
  localparam int SPI_FIFO_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } spi_state_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word fall-through FIFO with registered count and flush.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = SPI_DATA_LENGTH,
  parameter int FIFO_DEPTH  = SPI_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_LENGTH-1:0]      din,
  output logic [DATA_LENGTH-1:0]      dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   do_push, do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // flush wins over both sides so a flushed queue cannot be refilled in the same edge
  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spi_tx_scheduler.sv
// Feeds queued bytes to the SPI master as fixed-length tx_en frames with a
// guaranteed low gap between frames so slave-select deasserts.
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = SPI_DATA_LENGTH,
  parameter int FIFO_DEPTH  = SPI_FIFO_DEPTH,
  parameter int XFER_CYCLES = 20,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_LENGTH-1:0]      wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic                        flush,
  output logic                        tx_en,
  output logic [DATA_LENGTH-1:0]      tx_data,
  output logic                        busy,
  output logic                        xfer_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int MAXC = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  spi_state_t             state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   tx_en_n, done_n;
  logic [DATA_LENGTH-1:0] tx_data_n;
  logic                   fifo_full, fifo_empty, pop, start;
  logic [DATA_LENGTH-1:0] fifo_dout;

  spi_sync_fifo #(.DATA_LENGTH(DATA_LENGTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (wr_valid),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wr_ready = ~fifo_full;
  assign busy     = (state != IDLE) | ~fifo_empty;
  // The last gap cycle may launch directly, giving exactly GAP_CYCLES low cycles.
  assign start    = ~fifo_empty & ~flush &
                    ((state == IDLE) || (state == GAP && cnt == '0));

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tx_en_n   = tx_en;
    tx_data_n = tx_data;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      XFER: begin
        if (cnt == '0) begin
          tx_en_n = 1'b0;
          done_n  = 1'b1;
          cnt_n   = CW'(GAP_CYCLES - 1);
          state_n = GAP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      pop       = 1'b1;
      tx_data_n = fifo_dout;
      tx_en_n   = 1'b1;
      cnt_n     = CW'(XFER_CYCLES - 1);
      state_n   = XFER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      xfer_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tx_en     <= tx_en_n;
      tx_data   <= tx_data_n;
      xfer_done <= done_n;
    end
  end
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Bench for spi_tx_scheduler: timestamp/queue model compared every cycle plus directed literal checks.
module tb_spi_tx_scheduler;
  localparam int DL = 8, DEPTH = 16, X = 20, G = 4;
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, flush, wr_valid, wr_ready, tx_en, busy, xfer_done;
  logic [DL-1:0]   wr_data, tx_data;
  logic [CNTW-1:0] fifo_count;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  spi_tx_scheduler #(.DATA_LENGTH(DL), .FIFO_DEPTH(DEPTH), .XFER_CYCLES(X), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .flush(flush), .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .xfer_done(xfer_done),
    .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Model: a queue of pending bytes plus the edge index at which the current frame started.
  int         cyc = 0;
  logic [7:0] mq[$];
  logic [7:0] m_data = '0;
  bit         m_started = 0, m_full, m_launch, last_rst = 0, model_live = 0;
  int         m_start = 0, m_next_ok = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    last_rst = rst;
    model_live = 1;
    if (rst) begin
      mq.delete(); m_data = '0; m_started = 0; m_next_ok = 0;
    end else begin
      m_full   = (mq.size() >= DEPTH);
      m_launch = !flush && (mq.size() != 0) && (cyc >= m_next_ok);
      if (m_launch) begin
        m_data = mq.pop_front(); m_started = 1; m_start = cyc; m_next_ok = cyc + X + G;
      end
      if (flush) mq.delete();
      else if (wr_valid && !m_full) mq.push_back(wr_data);
    end
  end

  // Event logs and scoreboard
  int         rise_cyc[$], fall_cyc[$], done_cyc[$];
  logic [7:0] rise_dat[$], sb[$];
  bit         sb_en = 0, prev_en = 0;
  int         run = 0;
  bit         e_en, e_done, e_busy, e_rdy;

  always @(negedge clk) begin
    if (model_live) begin
      e_en   = m_started && (cyc - m_start) < X;
      e_done = m_started && (cyc - m_start) == X;
      e_busy = (mq.size() != 0) || (m_started && (cyc - m_start) < X + G);
      e_rdy  = mq.size() < DEPTH;
      chk($sformatf("cycle%0d{en,done,busy,rdy,cnt,data}", cyc),
          {15'd0, tx_en, xfer_done, busy, wr_ready, fifo_count, tx_data},
          {15'd0, e_en, e_done, e_busy, e_rdy, CNTW'(mq.size()), m_data});
      if (tx_en && !prev_en) begin
        rise_cyc.push_back(cyc); rise_dat.push_back(tx_data);
        if (sb_en) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else chk("sb_order", tx_data, sb.pop_front());
        end
      end
      if (!tx_en && prev_en) begin
        fall_cyc.push_back(cyc);
        if (!last_rst) chk("run_len", run, X);
      end
      if (xfer_done) done_cyc.push_back(cyc);
      run = tx_en ? (prev_en ? run + 1 : 1) : 0;
      prev_en = tx_en;
    end
  end

  task automatic tick; @(negedge clk); endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1; wr_data = d; tick; wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    for (int i = 0; i < maxc && busy; i++) tick;
    chk(name, busy, 0);
  endtask

  task automatic clr_logs;
    rise_cyc.delete(); fall_cyc.delete(); done_cyc.delete(); rise_dat.delete();
  endtask

  int n, acc;

  initial begin
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0;
    repeat (3) tick;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_done", xfer_done, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    tick;

    // 1: single byte latency, frame length, one done pulse at fall
    clr_logs;
    push(8'hA5);
    n = cyc;
    chk("t1_count_after_push", fifo_count, 1);
    chk("t1_en_after_push", tx_en, 0);
    tick;
    chk("t1_en_next", tx_en, 1);
    chk("t1_data", tx_data, 8'hA5);
    wait_idle(100, "t1_idle");
    chk("t1_rises", rise_cyc.size(), 1);
    chk("t1_rise_at", rise_cyc[0], n + 1);
    chk("t1_len", fall_cyc[0] - rise_cyc[0], 20);
    chk("t1_done_n", done_cyc.size(), 1);
    chk("t1_done_at_fall", done_cyc[0], fall_cyc[0]);
    chk("t1_data_hold", tx_data, 8'hA5);

    // 2: back-to-back frames, exact gap, order
    clr_logs;
    push(8'h11);
    push(8'h22);
    chk("t2_popush_count", fifo_count, 1);
    push(8'h33);
    wait_idle(200, "t2_idle");
    chk("t2_rises", rise_cyc.size(), 3);
    chk("t2_d0", rise_dat[0], 8'h11);
    chk("t2_d1", rise_dat[1], 8'h22);
    chk("t2_d2", rise_dat[2], 8'h33);
    chk("t2_space01", rise_cyc[1] - rise_cyc[0], 24);
    chk("t2_space12", rise_cyc[2] - rise_cyc[1], 24);
    chk("t2_gap", rise_cyc[1] - fall_cyc[0], 4);

    // 3: fill to full during a frame, overflow write ignored
    clr_logs;
    push(8'h01);
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    chk("t3_count_full", fifo_count, 16);
    chk("t3_wr_ready", wr_ready, 0);
    chk("t3_in_flight", tx_en, 1);
    push(8'hEE);
    chk("t3_overflow_ignored", fifo_count, 16);
    chk("t3_busy", busy, 1);
    rst = 1'b1; tick; rst = 1'b0;
    chk("t3_reset_count", fifo_count, 0);
    tick;

    // 4: flush during the first frame's XFER
    clr_logs;
    for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
    chk("t4_count", fifo_count, 4);
    repeat (3) tick;
    chk("t4_xfer", tx_en, 1);
    flush = 1'b1; tick; flush = 1'b0;
    chk("t4_flushed", fifo_count, 0);
    chk("t4_still_xfer", tx_en, 1);
    wait_idle(200, "t4_idle");
    chk("t4_rises", rise_cyc.size(), 1);
    chk("t4_done", done_cyc.size(), 1);
    chk("t4_len", fall_cyc[0] - rise_cyc[0], 20);

    // 5: reset in cycle 10 of a frame
    clr_logs;
    push(8'h51);
    push(8'h52);
    repeat (9) tick;
    chk("t5_pre_en", tx_en, 1);
    rst = 1'b1; tick; rst = 1'b0;
    chk("t5_en", tx_en, 0);
    chk("t5_done", xfer_done, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", busy, 0);
    repeat (5) tick;
    chk("t5_no_done", done_cyc.size(), 0);
    chk("t5_rises", rise_cyc.size(), 1);

    // 6: random traffic with scoreboard
    clr_logs;
    sb_en = 1; acc = 0;
    for (int i = 0; i < 600; i++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data  = 8'($urandom);
      if (wr_valid && wr_ready) begin sb.push_back(wr_data); acc++; end
      tick;
    end
    wr_valid = 1'b0;
    wait_idle(2000, "t6_idle");
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_frames", rise_cyc.size(), acc);
    sb_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end
endmodule
